// File: rtl/sipo_frame_rx_ctrl.sv
// Framed serial receiver: start-bit detect, WIDTH-bit shift-in, stop-bit check,
// and a valid/ready holding register for the received word.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | line idle, waiting for a 0 start bit
// SHIFT     | shifting data bits, one per clock
// STOP      | sampling the stop bit, publishing the word if it is 1
// WAIT_HIGH | bad stop bit seen, waiting for the line to return high
module sipo_frame_rx_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             serial_in,
   input  logic             data_ready,
   output logic [WIDTH-1:0] parallel_out,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SHIFT     = 2'd1,
      STOP      = 2'd2,
      WAIT_HIGH = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] bit_cnt;
   logic          cnt_clr;
   logic          shift_en;
   logic          frame_good;
   logic          frame_bad;
   logic          load_word;

   // Frame state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and per-state datapath controls.
   always_comb begin
      state_nxt  = state;
      cnt_clr    = 1'b0;
      shift_en   = 1'b0;
      frame_good = 1'b0;
      frame_bad  = 1'b0;
      case (state)
         IDLE: begin
            if (!serial_in) begin
               state_nxt = SHIFT;
               cnt_clr   = 1'b1;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (bit_cnt == LAST_BIT) begin
               state_nxt = STOP;
            end
         end
         STOP: begin
            if (serial_in) begin
               frame_good = 1'b1;
               state_nxt  = IDLE;
            end else begin
               frame_bad = 1'b1;
               state_nxt = WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            if (serial_in) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A good frame is taken when the holding register is empty or being drained
   // on this same edge; otherwise the new word is dropped and overrun flagged.
   assign load_word = frame_good && (!data_valid || data_ready);
   assign busy      = (state == SHIFT) || (state == STOP);

   // Bit counter and shift register; parallel_out only moves while shifting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt      <= '0;
         parallel_out <= '0;
      end else begin
         if (cnt_clr) begin
            bit_cnt <= '0;
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (shift_en) begin
            parallel_out <= {parallel_out[WIDTH-2:0], serial_in};
         end
      end
   end

   // Output holding register, handshake and status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= frame_bad;
         overrun   <= frame_good && data_valid && !data_ready;
         if (load_word) begin
            data_out   <= parallel_out;
            data_valid <= 1'b1;
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sipo_frame_rx_ctrl.sv
// Directed bench for sipo_frame_rx_ctrl with hand-computed expectations.
module tb_sipo_frame_rx_ctrl;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst;
   logic             serial_in;
   logic             data_ready;
   logic [WIDTH-1:0] parallel_out;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             busy;
   logic             frame_err;
   logic             overrun;

   int n_checks = 0;
   int n_errors = 0;
   int busy_cnt;
   int err_cnt;
   int ovr_cnt;
   int valid_cnt;

   sipo_frame_rx_ctrl #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .serial_in    (serial_in),
      .data_ready   (data_ready),
      .parallel_out (parallel_out),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .busy         (busy),
      .frame_err    (frame_err),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_cnt();
      busy_cnt  = 0;
      err_cnt   = 0;
      ovr_cnt   = 0;
      valid_cnt = 0;
   endtask

   // Drive one serial bit, let one edge pass, sample 1 ns after it.
   task automatic clk_bit(input logic v);
      serial_in = v;
      @(posedge clk);
      #1;
      if (busy)       busy_cnt++;
      if (frame_err)  err_cnt++;
      if (overrun)    ovr_cnt++;
      if (data_valid) valid_cnt++;
   endtask

   task automatic check_reset(input string tag);
      check_val({tag, "_par"},   32'(parallel_out), 32'h0);
      check_val({tag, "_dout"},  32'(data_out),     32'h0);
      check_val({tag, "_valid"}, 32'(data_valid),   32'h0);
      check_val({tag, "_busy"},  32'(busy),         32'h0);
      check_val({tag, "_ferr"},  32'(frame_err),    32'h0);
      check_val({tag, "_ovr"},   32'(overrun),      32'h0);
   endtask

   initial begin
      rst        = 1'b1;
      serial_in  = 1'b1;
      data_ready = 1'b0;
      clr_cnt();
      repeat (2) @(posedge clk);
      #1;
      check_reset("rst0");
      rst = 1'b0;

      // Frame 1011, consumer not ready.
      clr_cnt();
      clk_bit(1'b0);
      check_val("f1_busy_start", 32'(busy), 32'h1);
      clk_bit(1'b1);
      check_val("f1_par1", 32'(parallel_out), 32'h1);
      clk_bit(1'b0);
      clk_bit(1'b1);
      clk_bit(1'b1);
      check_val("f1_par", 32'(parallel_out), 32'hB);
      check_val("f1_valid_early", 32'(data_valid), 32'h0);
      clk_bit(1'b1);
      check_val("f1_dout", 32'(data_out), 32'hB);
      check_val("f1_valid", 32'(data_valid), 32'h1);
      check_val("f1_busy_end", 32'(busy), 32'h0);
      clk_bit(1'b1);
      check_val("f1_busy_cycles", 32'(busy_cnt), 32'd5);
      check_val("f1_pulses", 32'(err_cnt + ovr_cnt), 32'd0);

      // Overrun: frame 0110 while 1011 is still pending.
      clr_cnt();
      clk_bit(1'b0);
      clk_bit(1'b0);
      clk_bit(1'b1);
      clk_bit(1'b1);
      clk_bit(1'b0);
      clk_bit(1'b1);
      check_val("ovr_pulse", 32'(overrun), 32'h1);
      check_val("ovr_dout", 32'(data_out), 32'hB);
      check_val("ovr_par", 32'(parallel_out), 32'h6);
      clk_bit(1'b1);
      check_val("ovr_once", 32'(ovr_cnt), 32'd1);
      check_val("ovr_valid_held", 32'(data_valid), 32'h1);
      data_ready = 1'b1;
      clk_bit(1'b1);
      data_ready = 1'b0;
      check_val("drain_valid", 32'(data_valid), 32'h0);
      check_val("drain_dout", 32'(data_out), 32'hB);

      // Bad stop bit, line stuck low for three cycles.
      clr_cnt();
      clk_bit(1'b0);
      clk_bit(1'b1);
      clk_bit(1'b1);
      clk_bit(1'b1);
      clk_bit(1'b1);
      clk_bit(1'b0);
      check_val("ferr_pulse", 32'(frame_err), 32'h1);
      check_val("ferr_busy", 32'(busy), 32'h0);
      busy_cnt = 0;
      clk_bit(1'b0);
      clk_bit(1'b0);
      clk_bit(1'b0);
      check_val("ferr_no_restart", 32'(busy_cnt), 32'd0);
      check_val("ferr_once", 32'(err_cnt), 32'd1);
      clk_bit(1'b1);
      clk_bit(1'b1);
      check_val("ferr_valid", 32'(valid_cnt), 32'd0);
      check_val("ferr_dout", 32'(data_out), 32'hB);
      check_val("ferr_par", 32'(parallel_out), 32'hF);

      // Back-to-back frames 1100 then 0011, consumer always ready.
      clr_cnt();
      data_ready = 1'b1;
      clk_bit(1'b0);
      clk_bit(1'b1);
      clk_bit(1'b1);
      clk_bit(1'b0);
      clk_bit(1'b0);
      clk_bit(1'b1);
      check_val("b2b_valid1", 32'(data_valid), 32'h1);
      check_val("b2b_dout1", 32'(data_out), 32'hC);
      clk_bit(1'b0);
      check_val("b2b_busy2", 32'(busy), 32'h1);
      clk_bit(1'b0);
      clk_bit(1'b0);
      clk_bit(1'b1);
      clk_bit(1'b1);
      clk_bit(1'b1);
      data_ready = 1'b0;
      check_val("b2b_valid2", 32'(data_valid), 32'h1);
      check_val("b2b_dout2", 32'(data_out), 32'h3);
      check_val("b2b_no_ovr", 32'(ovr_cnt), 32'd0);

      // Reset after two data bits of a frame, then receive 0110.
      clk_bit(1'b0);
      clk_bit(1'b1);
      clk_bit(1'b0);
      check_val("mid_par", 32'(parallel_out), 32'hE);
      rst = 1'b1;
      #1;
      check_reset("rst_mid");
      serial_in = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clr_cnt();
      clk_bit(1'b0);
      clk_bit(1'b0);
      clk_bit(1'b1);
      clk_bit(1'b1);
      clk_bit(1'b0);
      clk_bit(1'b1);
      check_val("post_rst_dout", 32'(data_out), 32'h6);
      check_val("post_rst_valid", 32'(data_valid), 32'h1);
      check_val("post_rst_busy", 32'(busy_cnt), 32'd5);

      // Idle line after reset.
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clr_cnt();
      for (int i = 0; i < 20; i++) clk_bit(1'b1);
      check_val("idle_busy", 32'(busy_cnt), 32'd0);
      check_val("idle_valid", 32'(valid_cnt), 32'd0);
      check_val("idle_ferr", 32'(err_cnt), 32'd0);
      check_val("idle_ovr", 32'(ovr_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sipo_frame_rx_ctrl.md
# sipo_frame_rx_ctrl

Controller that sequences the 4-bit serial-in/parallel-out shift register datapath into a framed serial receiver. It detects a start bit, shifts exactly WIDTH data bits, checks a stop bit, then publishes the word on a valid/ready output port. It sits between a raw one-bit-per-clock serial line and any parallel consumer. It owns the shift register, bit counter, frame FSM and output holding register.

## Interface
- WIDTH, 4, data bits per frame (≥2)
- clk  input  1  rising-edge clock; one serial bit per cycle
- rst  input  1  asynchronous, active-high reset
- serial_in  input  1  serial line; idle high, start bit 0, stop bit 1
- data_ready  input  1  consumer accepts data_out this cycle
- parallel_out  output  WIDTH  live shift-register contents
- data_out  output  WIDTH  last accepted frame word (holding register)
- data_valid  output  1  data_out holds an unconsumed word
- busy  output  1  high in SHIFT and STOP states
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- overrun  output  1  one-cycle pulse: good frame dropped because data_valid was pending

## Operation
- Shift rule, per SHIFT-state edge: parallel_out <= {parallel_out[WIDTH-2:0], serial_in}. The first data bit ends at the MSB.
- Bit counter: width $clog2(WIDTH+1). Cleared on entry to SHIFT; increments each SHIFT edge.
- States:
  - IDLE: serial_in==0 on an edge → SHIFT, counter=0. Otherwise stay.
  - SHIFT: shift one bit per edge. After the WIDTH-th bit → STOP.
  - STOP: sample serial_in.
    - If 1: good frame → IDLE.
    - If 0: pulse frame_err → WAIT_HIGH.
  - WAIT_HIGH: stay until serial_in==1 → IDLE. This prevents a stuck-low line from retriggering start detection.
- Good frame, data_valid==0: data_out <= parallel_out; data_valid <= 1.
- Good frame, data_valid==1 and data_ready==0: data_out is unchanged, pulse overrun, new word discarded.
- Good frame on the same edge as data_valid&&data_ready: data_out <= new word, data_valid stays 1, no overrun.
- data_valid&&data_ready with no completing frame: data_valid <= 0; data_out keeps its value.
- An errored frame never updates data_out or data_valid.
- parallel_out is not cleared between frames. It changes only in SHIFT.
- data_ready is ignored while data_valid==0.

## Timing
- Reset values, applied asynchronously while rst is high:
  - state=IDLE, counter=0
  - parallel_out=0, data_out=0
  - data_valid=0, busy=0, frame_err=0, overrun=0
- Reset mid-frame aborts immediately. After rst falls, the first edge is treated as IDLE.
- Latency: start bit sampled at edge k. Data bits are sampled at edges k+1 … k+WIDTH. The stop bit is sampled at edge k+WIDTH+1. data_valid is high after edge k+WIDTH+1.
- Back-to-back frames: the next start bit may be sampled at edge k+WIDTH+2, giving zero idle cycles.
- busy is high from after edge k through edge k+WIDTH+1. It is low in IDLE and WAIT_HIGH.
- frame_err and overrun are registered. Each is high for exactly the one cycle after the stop-sample edge.
- Handshake: a word transfers on any edge where data_valid && data_ready. The consumer may hold data_ready high continuously.

## Test plan
- Reset, then serial_in sequence 0,1,0,1,1,1 (start, 1011, stop), data_ready=0 → parallel_out=4'b1011; data_out=4'b1011, data_valid=1 after edge 6; busy high for 5 cycles; no pulses.
- With the word above pending and data_ready=0, send frame 0,0,1,1,0,1 → overrun pulses once; data_out stays 4'b1011. Then data_ready=1 for one edge → data_valid=0.
- Frame 0,1,1,1,1,0 (bad stop), line held 0 for 3 more cycles, then 1 → frame_err pulses once; state stays WAIT_HIGH (busy=0, no restart); data_valid unchanged.
- Back-to-back frames 4'b1100 then 4'b0011 with no idle cycles, data_ready tied 1 → data_valid high on both completion cycles; data_out=4'b1100, then 4'b0011; no overrun.
- Assert rst for one cycle after 2 data bits of a frame → all outputs return to reset values at once. The following frame 4'b0110 is received correctly.
- Line held 1 for 20 cycles after reset → busy, data_valid, frame_err and overrun all stay 0.
